// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] BusAddr;
  logic [DATA_WIDTH-1:0] BusWData;
  logic [3:0]            BusByteEn;
  logic                  BusWE;
  logic                  BusValid;
  logic                  BusReady;
  logic                  BusRespValid;
  logic [DATA_WIDTH-1:0] BusRData;

  modport master (
    output BusAddr, BusWData, BusByteEn, BusWE, BusValid,
    input  BusReady, BusRespValid, BusRData
  );

  modport slave (
    input  BusAddr, BusWData, BusByteEn, BusWE, BusValid,
    output BusReady, BusRespValid, BusRData
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per instruction, stalls while in flight.
// Optional response watchdog enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FUNCT3_WIDTH   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [DATA_WIDTH-1:0]   WriteData,
  input  logic                    MemRead,
  input  logic                    MemWrite,
  input  logic [FUNCT3_WIDTH-1:0] Funct3,
  output logic                    Stall,
  output logic [DATA_WIDTH-1:0]   ReadData,
  output logic                    LoadValid,
  output logic                    AccessErr,
  load_store_unit_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state, state_n;
  logic [1:0]            off_q;
  logic [2:0]            f3_q;
  logic [2:0]            f3_c;
  logic                  req_c, store_c, misalign_c, illegal_c;
  logic                  load_done_c, err_set_c, timeout_c;
  logic [DATA_WIDTH-1:0] shifted_c, ext_c;

  assign f3_c       = 3'(Funct3);
  assign req_c      = MemRead | MemWrite;
  assign store_c    = MemWrite;
  assign misalign_c = ((f3_c[1:0] == 2'b01) && ALUResult[0]) ||
                      ((f3_c[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
  assign illegal_c  = (f3_c == 3'b011) || (f3_c[2:1] == 2'b11) || (store_c && f3_c[2]);
  assign bus.BusValid = (state == REQ);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tcnt;

  // Cycles spent in REQ/WAIT; reset while idle so it starts at zero on entering REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                tcnt <= '0;
    else if ((state == REQ) || (state == WAIT)) tcnt <= tcnt + CNT_W'(1);
    else                                    tcnt <= '0;
  end

  assign timeout_c = (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state, stall and completion strobes; a handshake or response beats the watchdog.
  always_comb begin
    state_n     = state;
    Stall       = 1'b0;
    load_done_c = 1'b0;
    err_set_c   = 1'b0;
    case (state)
      IDLE: begin
        if (req_c) begin
          Stall = 1'b1;
          if (misalign_c || illegal_c) begin
            state_n   = DONE;
            err_set_c = 1'b1;
          end else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (bus.BusReady) begin
          state_n = bus.BusWE ? DONE : WAIT;
        end else if (timeout_c) begin
          state_n   = DONE;
          err_set_c = 1'b1;
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (bus.BusRespValid) begin
          state_n     = DONE;
          load_done_c = 1'b1;
        end else if (timeout_c) begin
          state_n   = DONE;
          err_set_c = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Align the addressed lane to bit 0, then extend per access size.
  always_comb begin
    shifted_c = bus.BusRData >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_c = {{(DATA_WIDTH-8){shifted_c[7]}},   shifted_c[7:0]};
      3'b001:  ext_c = {{(DATA_WIDTH-16){shifted_c[15]}}, shifted_c[15:0]};
      3'b100:  ext_c = {{(DATA_WIDTH-8){1'b0}},           shifted_c[7:0]};
      3'b101:  ext_c = {{(DATA_WIDTH-16){1'b0}},          shifted_c[15:0]};
      default: ext_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q         <= '0;
      f3_q          <= '0;
      ReadData      <= '0;
      LoadValid     <= 1'b0;
      AccessErr     <= 1'b0;
      bus.BusAddr   <= '0;
      bus.BusWData  <= '0;
      bus.BusByteEn <= '0;
      bus.BusWE     <= 1'b0;
    end else begin
      LoadValid <= load_done_c;
      AccessErr <= err_set_c;
      if (load_done_c) ReadData <= ext_c;
      if ((state == IDLE) && req_c) begin
        off_q       <= ALUResult[1:0];
        f3_q        <= f3_c;
        bus.BusAddr <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
        bus.BusWE   <= store_c;
        if (store_c && (f3_c[1:0] == 2'b00)) begin
          bus.BusByteEn <= 4'(4'b0001 << ALUResult[1:0]);
          bus.BusWData  <= {4{WriteData[7:0]}};
        end else if (store_c && (f3_c[1:0] == 2'b01)) begin
          bus.BusByteEn <= 4'(4'b0011 << ALUResult[1:0]);
          bus.BusWData  <= {2{WriteData[15:0]}};
        end else begin
          bus.BusByteEn <= 4'b1111;
          bus.BusWData  <= store_c ? WriteData : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (timeout case built with LSU_TIMEOUT_EN).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        MemRead, MemWrite, Stall, LoadValid, AccessErr;
  logic [2:0]  Funct3;

  int n_total = 0;
  int n_pass  = 0;

  load_store_unit_if bus_if ();

  load_store_unit #(.DATA_WIDTH(32), .FUNCT3_WIDTH(3), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .Stall(Stall),
    .ReadData(ReadData), .LoadValid(LoadValid), .AccessErr(AccessErr), .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one request and act as the memory; returns observed handshake/latency figures.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input int ready_delay, input logic [31:0] rdata,
                        output int stalls, output int lv, output int ae, output int bv,
                        output logic [31:0] baddr, output logic [31:0] bwdata,
                        output logic [3:0] ben, output logic bwe, output logic stable);
    int  wcnt;
    logic hs_load;
    logic done;
    stalls = 0; lv = 0; ae = 0; bv = 0; wcnt = 0; hs_load = 1'b0; done = 1'b0;
    baddr = '0; bwdata = '0; ben = '0; bwe = 1'b0; stable = 1'b1;
    @(negedge clk);
    ALUResult = addr; WriteData = wdata; Funct3 = f3;
    MemWrite = wr; MemRead = rd;
    bus_if.BusReady = 1'b0; bus_if.BusRespValid = 1'b0; bus_if.BusRData = rdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (Stall) stalls++;
      if (LoadValid) lv++;
      if (AccessErr) ae++;
      if (bus_if.BusValid) begin
        if (bv == 0) begin
          baddr = bus_if.BusAddr; bwdata = bus_if.BusWData;
          ben = bus_if.BusByteEn; bwe = bus_if.BusWE;
        end else if (baddr !== bus_if.BusAddr || bwdata !== bus_if.BusWData ||
                     ben !== bus_if.BusByteEn || bwe !== bus_if.BusWE) begin
          stable = 1'b0;
        end
        bv++;
      end
      if (c > 0 && !Stall) begin
        done = 1'b1;
        break;
      end
      bus_if.BusRespValid = hs_load;
      bus_if.BusReady     = bus_if.BusValid && (wcnt >= ready_delay);
      if (bus_if.BusValid) wcnt++;
      hs_load = bus_if.BusValid && bus_if.BusReady && !wr;
      @(negedge clk);
      if (c == 0) begin
        MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    if (!done) check("op_completes", 32'd0, 32'd1);
    bus_if.BusReady = 1'b0; bus_if.BusRespValid = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk); #1;
    if (LoadValid) lv++;
    if (AccessErr) ae++;
  endtask

  int stalls, lv, ae, bv;
  logic [31:0] baddr, bwdata;
  logic [3:0]  ben;
  logic        bwe, stable;

  initial begin
    rst = 1'b1; ALUResult = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = '0;
    bus_if.BusReady = 1'b0; bus_if.BusRespValid = 1'b0; bus_if.BusRData = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",     32'(Stall), 32'd0);
    check("rst_readdata",  ReadData, 32'd0);
    check("rst_loadvalid", 32'(LoadValid), 32'd0);
    check("rst_accesserr", 32'(AccessErr), 32'd0);
    check("rst_busvalid",  32'(bus_if.BusValid), 32'd0);
    check("rst_busaddr",   bus_if.BusAddr, 32'd0);
    check("rst_byteen",    32'(bus_if.BusByteEn), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_stall", 32'(Stall), 32'd0);
    check("idle_busvalid", 32'(bus_if.BusValid), 32'd0);

    // LW zero-wait
    run_op(1'b0, 1'b1, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("lw_addr", baddr, 32'h100);
    check("lw_ben", 32'(ben), 32'hF);
    check("lw_we", 32'(bwe), 32'd0);
    check("lw_stalls", 32'(stalls), 32'd3);
    check("lw_loadvalid", 32'(lv), 32'd1);
    check("lw_err", 32'(ae), 32'd0);
    check("lw_data", ReadData, 32'hDEADBEEF);

    run_op(1'b0, 1'b1, 32'h103, 32'h0, 3'b000, 0, 32'h80FF_0000,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("lb_addr", baddr, 32'h100);
    check("lb_data", ReadData, 32'hFFFFFF80);
    run_op(1'b0, 1'b1, 32'h103, 32'h0, 3'b100, 0, 32'h80FF_0000,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("lbu_data", ReadData, 32'h00000080);
    run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b101, 0, 32'h80FF_0000,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("lhu_data", ReadData, 32'h000080FF);
    run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b001, 0, 32'h80FF_0000,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("lh_data", ReadData, 32'hFFFF80FF);

    // SB with a slow bus
    run_op(1'b1, 1'b0, 32'h201, 32'h12345678, 3'b000, 4, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("sb_addr", baddr, 32'h200);
    check("sb_wdata", bwdata, 32'h78787878);
    check("sb_ben", 32'(ben), 32'h2);
    check("sb_we", 32'(bwe), 32'd1);
    check("sb_stable", 32'(stable), 32'd1);
    check("sb_req_cycles", 32'(bv), 32'd5);
    check("sb_stalls", 32'(stalls), 32'd6);
    check("sb_loadvalid", 32'(lv), 32'd0);

    run_op(1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 3'b010, 0, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("sw_wdata", bwdata, 32'hCAFEF00D);
    check("sw_ben", 32'(ben), 32'hF);
    check("sw_stalls", 32'(stalls), 32'd2);

    run_op(1'b1, 1'b0, 32'h302, 32'h1234ABCD, 3'b001, 0, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("sh_wdata", bwdata, 32'hABCDABCD);
    check("sh_ben", 32'(ben), 32'hC);

    // Both requests high: store wins
    run_op(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 3'b010, 0, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("prio_we", 32'(bwe), 32'd1);
    check("prio_loadvalid", 32'(lv), 32'd0);
    check("prio_data_kept", ReadData, 32'hFFFF80FF);

    // Misaligned and illegal accesses never reach the bus
    run_op(1'b0, 1'b1, 32'h102, 32'h0, 3'b010, 0, 32'h11111111,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("mis_busvalid", 32'(bv), 32'd0);
    check("mis_err", 32'(ae), 32'd1);
    check("mis_stalls", 32'(stalls), 32'd1);
    check("mis_data_kept", ReadData, 32'hFFFF80FF);
    run_op(1'b0, 1'b1, 32'h100, 32'h0, 3'b011, 0, 32'h11111111,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("ill_busvalid", 32'(bv), 32'd0);
    check("ill_err", 32'(ae), 32'd1);
    check("ill_data_kept", ReadData, 32'hFFFF80FF);
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b100, 0, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("ill_store_err", 32'(ae), 32'd1);
    check("ill_store_busvalid", 32'(bv), 32'd0);

`ifdef LSU_TIMEOUT_EN
    run_op(1'b0, 1'b1, 32'h500, 32'h0, 3'b010, 1000, 32'h0,
           stalls, lv, ae, bv, baddr, bwdata, ben, bwe, stable);
    check("to_req_cycles", 32'(bv), 32'd8);
    check("to_err", 32'(ae), 32'd1);
    check("to_stalls", 32'(stalls), 32'd9);
    check("to_loadvalid", 32'(lv), 32'd0);
`endif

    // Reset while waiting for a load response
    @(negedge clk);
    ALUResult = 32'h600; Funct3 = 3'b010; MemRead = 1'b1;
    @(negedge clk);
    MemRead = 1'b0; bus_if.BusReady = 1'b1;
    @(negedge clk); #1;
    bus_if.BusReady = 1'b0;
    check("wait_stall", 32'(Stall), 32'd1);
    check("wait_busvalid", 32'(bus_if.BusValid), 32'd0);
    rst = 1'b1; #1;
    check("midrst_stall", 32'(Stall), 32'd0);
    check("midrst_readdata", ReadData, 32'd0);
    check("midrst_busaddr", bus_if.BusAddr, 32'd0);
    @(negedge clk);
    rst = 1'b0; bus_if.BusRespValid = 1'b1; bus_if.BusRData = 32'h55;
    @(negedge clk); #1;
    bus_if.BusRespValid = 1'b0;
    check("late_loadvalid", 32'(LoadValid), 32'd0);
    check("late_readdata", ReadData, 32'd0);
    check("late_stall", 32'(Stall), 32'd0);
    check("late_busvalid", 32'(bus_if.BusValid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
